// File: rtl/mult_div_unit_pkg.sv
// Shared opcode, FSM state and operation-class helpers for the iterative
// multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // Opcode bit 0 selects unsigned, bit 1 selects divide.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; WIDTH steps per
// operation, with MTHI/MTLO writes serviced while idle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             mult_div_stall,
  output logic             mult_div_over,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  md_state_e          state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic               div_reg;
  logic               neg_q_reg, neg_r_reg, div_zero_reg;
  logic [WIDTH-1:0]   a_mag_reg, b_mag_reg, a_orig_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  // Operand magnitudes and sign flags for the accepting cycle
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = is_signed_op(op) & a[WIDTH-1];
    b_neg = is_signed_op(op) & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_mag_reg} : '0);
    mul_step  = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {acc_reg, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, b_mag_reg};
    div_step  = div_trial[WIDTH] ? div_shift[2*WIDTH-1:0]
                                 : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    acc_step  = div_reg ? div_step : mul_step;
  end

  // Sign correction of the completed step, used only on the final BUSY edge
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_fix = neg_q_reg ? (~acc_step + 1'b1) : acc_step;
    quo_fix  = neg_q_reg ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
    rem_fix  = neg_r_reg ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1) : acc_step[2*WIDTH-1:WIDTH];
    if (!div_reg) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero_reg) begin
      res_hi = a_orig_reg;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= MD_IDLE;
    else       state_reg <= state_next;
  end

  // DONE always returns to IDLE so a start still held there cannot relaunch
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (cnt_reg == LAST_CNT) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      div_reg      <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      a_mag_reg    <= '0;
      b_mag_reg    <= '0;
      a_orig_reg   <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
          if (start) begin
            cnt_reg      <= '0;
            div_reg      <= is_div_op(op);
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= (b == '0);
            a_mag_reg    <= a_mag;
            b_mag_reg    <= b_mag;
            a_orig_reg   <= a;
            acc_reg      <= is_div_op(op) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          end
        end
        MD_BUSY: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign mult_div_stall = start | (state_reg != MD_IDLE);
  assign mult_div_over  = (state_reg == MD_DONE);
  assign hi             = hi_reg;
  assign lo             = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic
// reference model of HI/LO results and operation timing.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         stall, over;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .mult_div_stall(stall), .mult_div_over(over), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {hi,lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    if (o == MD_OP_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
      return p;
    end
    if (o == MD_OP_MULT) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx * sy;
      return q;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == MD_OP_DIVU) return {x % y, x / y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: m_t = cycles since acceptance (0 = idle); results land entering cycle W+2
  int          m_t = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pending = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_hi = '0; m_lo = '0;
    end else if (m_t == 0) begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
      if (start) begin
        m_pending = ref_result(op, a, b);
        m_t = 1;
      end
    end else if (m_t == W) begin
      {m_hi, m_lo} = m_pending;
      m_t = W + 1;
    end else if (m_t == W + 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    chk("stall", 64'(stall), 64'(start | (m_t != 0)));
    chk("over", 64'(over), 64'(m_t == W + 1));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  end

  // Called at posedge+1 in an idle cycle; returns at posedge+1 after DONE
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit keep, input bit lit, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit done;
    n = 0; done = 0;
    op = o; a = x; b = y; start = 1'b1;
    for (int i = 1; i <= 100 && !done; i++) begin
      @(negedge clk);
      chk("stall_held", 64'(stall), 64'd1);
      if (over) begin
        n = i; done = 1;
      end else begin
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    chk("latency", 64'(n), 64'd34);
    if (done && lit) begin
      chk("hi_lit", 64'(hi), 64'(ehi));
      chk("lo_lit", 64'(lo), 64'(elo));
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h over_cycle=%0d", o, x, y, hi, lo, n);
    @(posedge clk); #1;
    if (!keep) begin
      start = 1'b0;
      @(negedge clk);
      chk("over_width", 64'(over), 64'd0);
      chk("stall_drop", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          rk;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_over", 64'(over), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(MD_OP_MULT,  32'hFFFF_FFFF, 32'd2,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(MD_OP_DIVU,  32'd100,       32'd7,         0, 1, 32'd2,         32'd14);
    run_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'd0,         32'h8000_0000);
    run_op(MD_OP_DIVU,  32'h1234_5678, 32'd0,         0, 1, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op(MD_OP_DIV,   32'h8765_4321, 32'd0,         0, 1, 32'h8765_4321, 32'hFFFF_FFFF);
    run_op(MD_OP_MULTU, 32'd6,         32'd7,         1, 1, 32'd0,         32'd42);
    run_op(MD_OP_MULTU, 32'd3,         32'd5,         0, 1, 32'd0,         32'd15);

    lo_we = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1;
    lo_we = 1'b0;
    @(negedge clk);
    chk("mtlo", 64'(lo), 64'hAA);
    $display("mtlo wdata=000000aa -> lo=%h", lo);
    @(posedge clk); #1;

    for (int it = 0; it < 40; it++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rk = (it != 39) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
      end
      run_op(ro, ra, rb, rk, 0, '0, '0);
      hi_we = 1'b0; lo_we = 1'b0;
    end

    op = MD_OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b1; start = 1'b0;
    #1;
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_over", 64'(over), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    $display("async reset mid-op -> stall=%0d over=%0d hi=%h lo=%h", stall, over, hi, lo);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(MD_OP_DIVU, 32'd1000, 32'd33, 0, 1, 32'd10, 32'd30);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
